// File: rtl/axi_axil_rd_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_if / axil_rd_if
// Description : AXI4 read-channel bundle (AR + R with ID/LAST) and
//               AXI4-Lite read-channel bundle used by axi_axil_rd_bridge.
// Revision    : 1.0 - initial release
// ============================================================================

interface axi_rd_if #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int ID_WIDTH = 10
);
  logic [ID_WIDTH-1:0] arid;
  logic [AW-1:0]       araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DW-1:0]       rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

interface axil_rd_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/axi_axil_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi_axil_rd_bridge
// Description : Splits an AXI4 read burst into one AXI4-Lite read per beat,
//               returning beats with the burst ID and a generated RLAST.
//               One burst in flight, in-order.
//               Optional macro AXI_AXIL_RD_WRAP_EN enables WRAP bursts;
//               without it WRAP is answered with SLVERR like a reserved type.
// Revision    : 1.0 - initial release
// ============================================================================

module axi_axil_rd_bridge #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int ID_WIDTH = 10
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  axi_rd_if.slave    s_axi,
  axil_rd_if.master  m_axil
);

  localparam int         c_MAX_SIZE  = $clog2(DW / 8);
  localparam logic [2:0] c_MAX_SIZE3 = 3'(c_MAX_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ID_WIDTH-1:0] r_id;
  logic [AW-1:0]       r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [2:0]          r_prot;
  logic [7:0]          r_cnt;

  logic [2:0]          w_ar_size;
  logic                w_bad_burst;
  logic                w_last;
  logic                w_beat_hs;
  logic [AW-1:0]       w_bytes;
  logic [AW-1:0]       w_incr_addr;
  logic [AW-1:0]       w_next_addr;

  // Beats wider than the bus are narrowed to the bus width.
  assign w_ar_size = (s_axi.arsize > c_MAX_SIZE3) ? c_MAX_SIZE3 : s_axi.arsize;

`ifdef AXI_AXIL_RD_WRAP_EN
  assign w_bad_burst = (s_axi.arburst == 2'b11);
`else
  assign w_bad_burst = s_axi.arburst[1];
`endif

  assign w_last      = (r_cnt == r_len);
  assign w_beat_hs   = ((r_state == S_DATA) && m_axil.rvalid && s_axi.rready) ||
                       ((r_state == S_ERR) && s_axi.rready);
  assign w_bytes     = AW'(1) << r_size;
  assign w_incr_addr = (r_addr & ~(w_bytes - AW'(1))) + w_bytes;

`ifdef AXI_AXIL_RD_WRAP_EN
  logic [AW-1:0] w_wrap_mask;
  logic [AW-1:0] w_wrap_addr;
  assign w_wrap_mask = ((AW'(r_len) + AW'(1)) << r_size) - AW'(1);
  assign w_wrap_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_bytes) & w_wrap_mask);
`endif

  // Address of the following beat for the latched burst type.
  always_comb begin
    w_next_addr = r_addr;
    case (r_burst)
      2'b01:   w_next_addr = w_incr_addr;
`ifdef AXI_AXIL_RD_WRAP_EN
      2'b10:   w_next_addr = w_wrap_addr;
`endif
      default: w_next_addr = r_addr;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic and all bus outputs; DATA is a combinational pass-through.
  always_comb begin
    w_next_state   = r_state;
    s_axi.arready  = 1'b0;
    s_axi.rid      = '0;
    s_axi.rdata    = '0;
    s_axi.rresp    = 2'b00;
    s_axi.rlast    = 1'b0;
    s_axi.rvalid   = 1'b0;
    m_axil.araddr  = '0;
    m_axil.arprot  = r_prot;
    m_axil.arvalid = 1'b0;
    m_axil.rready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        s_axi.arready = rst_n;
        if (s_axi.arvalid) w_next_state = w_bad_burst ? S_ERR : S_ADDR;
      end
      S_ADDR: begin
        m_axil.arvalid = 1'b1;
        m_axil.araddr  = r_addr;
        if (m_axil.arready) w_next_state = S_DATA;
      end
      S_DATA: begin
        s_axi.rvalid  = m_axil.rvalid;
        m_axil.rready = s_axi.rready;
        s_axi.rid     = r_id;
        s_axi.rdata   = m_axil.rdata;
        s_axi.rresp   = m_axil.rresp;
        s_axi.rlast   = w_last;
        if (w_beat_hs) w_next_state = w_last ? S_IDLE : S_ADDR;
      end
      S_ERR: begin
        s_axi.rvalid = 1'b1;
        s_axi.rid    = r_id;
        s_axi.rresp  = 2'b10;
        s_axi.rlast  = w_last;
        if (w_beat_hs && w_last) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Burst context: captured on AR accept, advanced on every non-final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_prot  <= '0;
      r_cnt   <= '0;
    end else if ((r_state == S_IDLE) && s_axi.arvalid) begin
      r_id    <= s_axi.arid;
      r_addr  <= s_axi.araddr;
      r_len   <= s_axi.arlen;
      r_size  <= w_ar_size;
      r_burst <= s_axi.arburst;
      r_prot  <= s_axi.arprot;
      r_cnt   <= '0;
    end else if (w_beat_hs && !w_last) begin
      r_cnt <= r_cnt + 8'd1;
      if (r_state == S_DATA) r_addr <= w_next_addr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_axil_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_axil_rd_bridge
// Description : Directed, table-driven bench for axi_axil_rd_bridge with a
//               cycle-accurate AXI master and AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_axi_axil_rd_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_rd_if  #(.DW(32), .AW(32), .ID_WIDTH(10)) s_if ();
  axil_rd_if #(.DW(32), .AW(32))                m_if ();

  axi_axil_rd_bridge #(.DW(32), .AW(32), .ID_WIDTH(10)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axi  (s_if),
    .m_axil (m_if)
  );

  typedef struct {
    logic [9:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             err;
    logic [3:0][31:0] exp_addr;
    logic [3:0][1:0]  lresp;
    int               ar_stall;
    int               r_stall;
    int               rst_beat;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [9:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic err,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [1:0] r0, input logic [1:0] r1,
                              input logic [1:0] r2, input logic [1:0] r3,
                              input int ars, input int rs);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.err = err;
    v.exp_addr = {a3, a2, a1, a0};
    v.lresp = {r3, r2, r1, r0};
    v.ar_stall = ars; v.r_stall = rs; v.rst_beat = 0;
    return v;
  endfunction

  // Beats past the fourth only occur in long aligned INCR size-2 bursts.
  function automatic logic [31:0] exp_addr_of(input vec_t v, input int k);
    if (k < 4) return v.exp_addr[k];
    return v.addr + 32'(4 * k);
  endfunction

  function automatic logic [31:0] lite_data(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  task automatic idle_inputs();
    s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
    s_if.arburst = '0; s_if.arprot = '0; s_if.arvalid = 1'b0; s_if.rready = 1'b0;
    m_if.arready = 1'b0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 1'b0;
  endtask

  task automatic run_burst(input vec_t v);
    int beats = 0, cyc = 0, ar_cnt = 0;
    int ar_st = v.ar_stall, r_st = v.r_stall;
    bit lite_pend = 0, done = 0, first = 1, hold_a = 0, hold_r = 0;
    logic [31:0] cur_a = '0, hold_addr = '0, hold_d = '0;

    @(negedge clk);
    idle_inputs();
    s_if.arid = v.id; s_if.araddr = v.addr; s_if.arlen = v.len;
    s_if.arsize = v.size; s_if.arburst = v.burst; s_if.arprot = v.id[2:0];
    s_if.arvalid = 1'b1;
    #1;
    while (!s_if.arready && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    chk("ar_accept", s_if.arready, 1'b1);
    if (!s_if.arready) begin s_if.arvalid = 1'b0; return; end
    @(negedge clk);
    s_if.arvalid = 1'b0;
    cyc = 0;

    while (!done && cyc < 2000) begin
      if (v.rst_beat > 0 && beats == v.rst_beat) begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_arready", s_if.arready, 1'b0);
        chk("rst_arvalid", m_if.arvalid, 1'b0);
        chk("rst_araddr",  m_if.araddr,  32'h0);
        chk("rst_arprot",  m_if.arprot,  3'h0);
        chk("rst_rvalid",  s_if.rvalid,  1'b0);
        chk("rst_rlast",   s_if.rlast,   1'b0);
        chk("rst_rid",     s_if.rid,     10'h0);
        chk("rst_mrready", m_if.rready,  1'b0);
        return;
      end
      m_if.arready = (ar_st == 0);
      m_if.rvalid  = lite_pend;
      m_if.rdata   = lite_pend ? lite_data(cur_a) : 32'h0;
      m_if.rresp   = lite_pend ? v.lresp[beats % 4] : 2'b00;
      s_if.rready  = (r_st == 0);
      #1;
      if (first) begin
        chk("arvalid_latency", m_if.arvalid, !v.err);
        first = 0;
      end
      if (m_if.arvalid) begin
        if (hold_a) chk("ar_hold", m_if.araddr, hold_addr);
        if (m_if.arready) begin
          ar_cnt++;
          chk("lite_addr", m_if.araddr, exp_addr_of(v, beats));
          chk("lite_prot", m_if.arprot, v.id[2:0]);
          cur_a = m_if.araddr;
          lite_pend = 1;
          hold_a = 0;
        end else begin
          ar_st--; hold_a = 1; hold_addr = m_if.araddr;
        end
      end
      if (s_if.rvalid) begin
        if (hold_r) chk("r_hold", s_if.rdata, hold_d);
        if (s_if.rready) begin
          chk("rid",   s_if.rid,   v.id);
          chk("rdata", s_if.rdata, v.err ? 32'h0 : lite_data(exp_addr_of(v, beats)));
          chk("rresp", s_if.rresp, v.err ? 2'b10 : v.lresp[beats % 4]);
          chk("rlast", s_if.rlast, beats == int'(v.len));
          beats++; lite_pend = 0; hold_r = 0;
          if (beats == int'(v.len) + 1) done = 1;
        end else begin
          r_st--; hold_r = 1; hold_d = s_if.rdata;
        end
      end
      cyc++;
      @(negedge clk);
    end
    chk("burst_done", done, 1'b1);
    chk("lite_ar_count", ar_cnt, v.err ? 0 : int'(v.len) + 1);
    idle_inputs();
    #1;
    chk("idle_return", s_if.arready, 1'b1);
  endtask

  vec_t vecs[9];
  vec_t vx;

  initial begin
    vecs[0] = mk(10'h015, 32'h1000, 8'd3, 3'd2, 2'b01, 1'b0,
                 32'h1000, 32'h1004, 32'h1008, 32'h100C, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
`ifdef AXI_AXIL_RD_WRAP_EN
    vecs[1] = mk(10'h02A, 32'h2038, 8'd3, 3'd2, 2'b10, 1'b0,
                 32'h2038, 32'h203C, 32'h2030, 32'h2034, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
`else
    vecs[1] = mk(10'h02A, 32'h2038, 8'd3, 3'd2, 2'b10, 1'b1,
                 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
`endif
    vecs[2] = mk(10'h003, 32'h0040, 8'd2, 3'd2, 2'b00, 1'b0,
                 32'h40, 32'h40, 32'h40, 32'h0, 2'd0, 2'd2, 2'd0, 2'd0, 0, 0);
    vecs[3] = mk(10'h1FF, 32'h0080, 8'd1, 3'd2, 2'b11, 1'b1,
                 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    vecs[4] = mk(10'h007, 32'h1003, 8'd2, 3'd2, 2'b01, 1'b0,
                 32'h1003, 32'h1004, 32'h1008, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    vecs[5] = mk(10'h0C1, 32'h0000, 8'd2, 3'd3, 2'b01, 1'b0,
                 32'h0, 32'h4, 32'h8, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    vecs[6] = mk(10'h055, 32'h3000, 8'd1, 3'd2, 2'b01, 1'b0,
                 32'h3000, 32'h3004, 32'h0, 32'h0, 2'd0, 2'd3, 2'd0, 2'd0, 3, 5);
    vecs[7] = mk(10'h10E, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 1'b0,
                 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    vecs[8] = mk(10'h0F0, 32'h0011, 8'd2, 3'd0, 2'b01, 1'b0,
                 32'h11, 32'h12, 32'h13, 32'h0, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0);

    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_arready", s_if.arready, 1'b0);
    chk("reset_arvalid", m_if.arvalid, 1'b0);
    chk("reset_rvalid",  s_if.rvalid,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_arready", s_if.arready, 1'b1);
    chk("release_arvalid", m_if.arvalid, 1'b0);
    chk("release_rvalid",  s_if.rvalid,  1'b0);
    chk("release_rlast",   s_if.rlast,   1'b0);

    for (int i = 0; i < 9; i++) run_burst(vecs[i]);

    // 256-beat burst: the 8-bit beat counter must reach 255 exactly.
    vx = mk(10'h03C, 32'h0, 8'd255, 3'd2, 2'b01, 1'b0,
            32'h0, 32'h4, 32'h8, 32'hC, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    run_burst(vx);

    // Reset while beat 2 of an 8-beat burst is pending, then a clean burst.
    vx = mk(10'h0AA, 32'h5000, 8'd7, 3'd2, 2'b01, 1'b0,
            32'h5000, 32'h5004, 32'h5008, 32'h500C, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    vx.rst_beat = 1;
    run_burst(vx);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst2_arready", s_if.arready, 1'b1);
    chk("rst2_arvalid", m_if.arvalid, 1'b0);
    run_burst(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
